// File: rtl/mode_dispatcher_if.sv
// Mode dispatcher signal bundle: buttons, key switches, mode/menu buses,
// status and key-remap write port. The dispatcher sits on the slave side.
interface mode_dispatcher_if #(
   parameter int KEYS      = 7,
   parameter int NUM_MODES = 4,
   parameter int NUM_SONGS = 2,
   parameter int OUT_W     = 24
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int SW = $clog2(NUM_SONGS + 1);
   localparam int KW = (KEYS > 1) ? $clog2(KEYS) : 1;

   logic                       submit;
   logic                       cancel;
   logic                       oct_up;
   logic                       oct_down;
   logic [KEYS-1:0]            note_key;
   logic [KEYS-1:0]            length_key;
   logic                       remap_clr;
   logic                       cue_busy;
   logic [NUM_MODES*OUT_W-1:0] mode_bus;
   logic [OUT_W-1:0]           menu_bus;
   logic [OUT_W-1:0]           out_bus;
   logic [NUM_MODES-1:0]       mode_en;
   logic [2:0]                 state;
   logic [MW-1:0]              mode_idx;
   logic [SW-1:0]              song;
   logic [1:0]                 sub_mode;
   logic [3:0]                 difficulty;
   logic                       remap_we;
   logic                       remap_rst;
   logic                       cue_start;
   logic [KW-1:0]              remap_addr;
   logic [KEYS-1:0]            remap_data;

   modport master (
      output submit, cancel, oct_up, oct_down, note_key, length_key,
             remap_clr, cue_busy, mode_bus, menu_bus,
      input  out_bus, mode_en, state, mode_idx, song, sub_mode, difficulty,
             remap_we, remap_rst, cue_start, remap_addr, remap_data
   );

   modport slave (
      input  submit, cancel, oct_up, oct_down, note_key, length_key,
             remap_clr, cue_busy, mode_bus, menu_bus,
      output out_bus, mode_en, state, mode_idx, song, sub_mode, difficulty,
             remap_we, remap_rst, cue_start, remap_addr, remap_data
   );
endinterface

// File: rtl/mode_dispatcher.sv
// Top-level play-mode dispatcher: debounced-edge button handling, menu/select/
// run/remap sequencing, output bundle muxing and key-remap table writes.
module mode_dispatcher #(
   parameter int                   KEYS        = 7,
   parameter int                   NUM_MODES   = 4,
   parameter int                   NUM_SONGS   = 2,
   parameter int                   OUT_W       = 24,
   parameter logic [NUM_MODES-1:0] NOSONG_MASK = 4'b0001,
   parameter logic [NUM_MODES-1:0] DIFF_MASK   = 4'b1000,
   parameter int                   DIFF_DEF    = 4,
   parameter int                   DIFF_MAX    = KEYS - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   mode_dispatcher_if.slave bus
);
   localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
   localparam int SW = $clog2(NUM_SONGS + 1);
   localparam int KW = (KEYS > 1) ? $clog2(KEYS) : 1;

   typedef enum logic [2:0] {
      ST_MENU   = 3'd0,
      ST_SELECT = 3'd1,
      ST_RUN    = 3'd2,
      ST_REMAP  = 3'd3
   } state_t;

   // Button order: {oct_down, oct_up, cancel, submit}
   logic [3:0] raw, pulse;
   logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
   logic [1:0] prime_q, prime_d;

   state_t               state_q, state_d;
   logic [MW-1:0]        mode_idx_q, mode_idx_d;
   logic [SW-1:0]        song_q, song_d;
   logic [1:0]           sub_mode_q, sub_mode_d;
   logic [3:0]           difficulty_q, difficulty_d;
   logic [KW-1:0]        idx_q, idx_d;
   logic [OUT_W-1:0]     out_bus_q, out_bus_d;
   logic [NUM_MODES-1:0] mode_en_q, mode_en_d;
   logic                 remap_we_q, remap_we_d, remap_rst_q, remap_rst_d;
   logic                 cue_start_q, cue_start_d;
   logic [KW-1:0]        remap_addr_q, remap_addr_d;
   logic [KEYS-1:0]      remap_data_q, remap_data_d;

   logic          note_ok, len_ok, sub_p, cancel_p, up_p, dn_p;
   logic [KW-1:0] note_idx, len_idx;

   function automatic logic [KW-1:0] key_enc(input logic [KEYS-1:0] k);
      key_enc = '0;
      for (int unsigned i = 0; i < KEYS; i++)
         if (k[i]) key_enc = KW'(i);
   endfunction

   assign raw = {bus.oct_down, bus.oct_up, bus.cancel, bus.submit};

   // History is held high until the sync chain has refilled after reset, so a
   // button held through reset release gives no pulse until pressed again.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      prime_d = {prime_q[0], 1'b1};
      hist_d  = prime_q[1] ? sync2_q : '1;
   end

   assign pulse    = sync2_q & ~hist_q;
   assign sub_p    = pulse[0];
   assign cancel_p = pulse[1];
   assign up_p     = pulse[2];
   assign dn_p     = pulse[3];
   assign note_ok  = $onehot(bus.note_key);
   assign len_ok   = $onehot(bus.length_key);
   assign note_idx = key_enc(bus.note_key);
   assign len_idx  = key_enc(bus.length_key);

   always_comb begin
      state_d      = state_q;
      mode_idx_d   = mode_idx_q;
      song_d       = song_q;
      sub_mode_d   = sub_mode_q;
      difficulty_d = difficulty_q;
      idx_d        = idx_q;
      remap_we_d   = 1'b0;
      remap_rst_d  = 1'b0;
      cue_start_d  = 1'b0;
      remap_addr_d = remap_addr_q;
      remap_data_d = remap_data_q;
      case (state_q)
         ST_MENU: begin
            if (sub_p && note_ok && int'(note_idx) < NUM_MODES) begin
               mode_idx_d   = MW'(note_idx);
               song_d       = '0;
               difficulty_d = 4'(DIFF_DEF);
               state_d      = NOSONG_MASK[MW'(note_idx)] ? ST_RUN : ST_SELECT;
            end else if (sub_p && note_ok && int'(note_idx) == NUM_MODES) begin
               state_d      = ST_REMAP;
               idx_d        = '0;
               remap_addr_d = '0;
            end
         end
         ST_SELECT: begin
            if (cancel_p) begin
               state_d = ST_MENU;
               song_d  = '0;
            end else begin
               if (DIFF_MASK[mode_idx_q] && (up_p ^ dn_p)) begin
                  if (up_p && difficulty_q < 4'(DIFF_MAX))
                     difficulty_d = difficulty_q + 4'd1;
                  else if (dn_p && difficulty_q != 4'd0)
                     difficulty_d = difficulty_q - 4'd1;
               end
               if (sub_p && note_ok && int'(note_idx) < NUM_SONGS) begin
                  song_d     = SW'(int'(note_idx) + 1);
                  sub_mode_d = (len_ok && int'(len_idx) < 4) ? 2'(len_idx) : 2'd0;
                  state_d    = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (cancel_p) begin
               state_d = ST_MENU;
               song_d  = '0;
            end
         end
         ST_REMAP: begin
            if (bus.remap_clr) begin
               remap_rst_d  = 1'b1;
               idx_d        = '0;
               remap_addr_d = '0;
               state_d      = ST_MENU;
            end else if (cancel_p) begin
               state_d = ST_MENU;
            end else if (sub_p && note_ok && !bus.cue_busy) begin
               remap_we_d   = 1'b1;
               cue_start_d  = 1'b1;
               remap_addr_d = idx_q;
               remap_data_d = bus.note_key;
               if (idx_q == KW'(KEYS - 1)) state_d = ST_MENU;
               else                        idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = ST_MENU;
      endcase
      mode_en_d = (state_d == ST_RUN) ? (NUM_MODES'(1) << mode_idx_d) : '0;
      out_bus_d = (state_q == ST_RUN) ? bus.mode_bus[int'(mode_idx_q)*OUT_W +: OUT_W]
                                      : bus.menu_bus;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         hist_q       <= '1;
         prime_q      <= '0;
         state_q      <= ST_MENU;
         mode_idx_q   <= '0;
         song_q       <= '0;
         sub_mode_q   <= '0;
         difficulty_q <= 4'(DIFF_DEF);
         idx_q        <= '0;
         out_bus_q    <= '0;
         mode_en_q    <= '0;
         remap_we_q   <= 1'b0;
         remap_rst_q  <= 1'b0;
         cue_start_q  <= 1'b0;
         remap_addr_q <= '0;
         remap_data_q <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         hist_q       <= hist_d;
         prime_q      <= prime_d;
         state_q      <= state_d;
         mode_idx_q   <= mode_idx_d;
         song_q       <= song_d;
         sub_mode_q   <= sub_mode_d;
         difficulty_q <= difficulty_d;
         idx_q        <= idx_d;
         out_bus_q    <= out_bus_d;
         mode_en_q    <= mode_en_d;
         remap_we_q   <= remap_we_d;
         remap_rst_q  <= remap_rst_d;
         cue_start_q  <= cue_start_d;
         remap_addr_q <= remap_addr_d;
         remap_data_q <= remap_data_d;
      end
   end

   assign bus.out_bus    = out_bus_q;
   assign bus.mode_en    = mode_en_q;
   assign bus.state      = state_q;
   assign bus.mode_idx   = mode_idx_q;
   assign bus.song       = song_q;
   assign bus.sub_mode   = sub_mode_q;
   assign bus.difficulty = difficulty_q;
   assign bus.remap_we   = remap_we_q;
   assign bus.remap_rst  = remap_rst_q;
   assign bus.cue_start  = cue_start_q;
   assign bus.remap_addr = remap_addr_q;
   assign bus.remap_data = remap_data_q;
endmodule

// File: tb/tb_mode_dispatcher.sv
// Directed self-checking bench for mode_dispatcher.
module tb_mode_dispatcher;
   localparam int KEYS      = 7;
   localparam int NUM_MODES = 4;
   localparam int NUM_SONGS = 2;
   localparam int OUT_W     = 24;

   localparam logic [23:0] SL0  = 24'h1A2B3C;
   localparam logic [23:0] SL1  = 24'h2B3C4D;
   localparam logic [23:0] SL2  = 24'h3C4D5E;
   localparam logic [23:0] SL3  = 24'h4D5E6F;
   localparam logic [23:0] MENU = 24'hC0FFEE;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mode_dispatcher_if #(.KEYS(KEYS), .NUM_MODES(NUM_MODES),
                        .NUM_SONGS(NUM_SONGS), .OUT_W(OUT_W)) bus ();

   mode_dispatcher #(.KEYS(KEYS), .NUM_MODES(NUM_MODES),
                     .NUM_SONGS(NUM_SONGS), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int we_cnt   = 0;
   int cue_cnt  = 0;
   int rst_cnt  = 0;
   logic [2:0] we_addr[$];
   logic [6:0] we_data[$];

   always @(negedge clk) begin
      if (bus.remap_we) begin
         we_addr.push_back(bus.remap_addr);
         we_data.push_back(bus.remap_data);
         we_cnt++;
      end
      if (bus.cue_start) cue_cnt++;
      if (bus.remap_rst) rst_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // b = {oct_down, oct_up, cancel, submit}
   task automatic press(input logic [3:0] b);
      @(negedge clk);
      {bus.oct_down, bus.oct_up, bus.cancel, bus.submit} = b;
      cyc(3);
      {bus.oct_down, bus.oct_up, bus.cancel, bus.submit} = 4'b0000;
      cyc(3);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.submit     = 1'b0;
      bus.cancel     = 1'b0;
      bus.oct_up     = 1'b0;
      bus.oct_down   = 1'b0;
      bus.note_key   = '0;
      bus.length_key = '0;
      bus.remap_clr  = 1'b0;
      bus.cue_busy   = 1'b0;
      bus.mode_bus   = {SL3, SL2, SL1, SL0};
      bus.menu_bus   = MENU;

      cyc(2);
      chk("rst_state",    64'(bus.state),      64'(0));
      chk("rst_mode_en",  64'(bus.mode_en),    64'(0));
      chk("rst_out_bus",  64'(bus.out_bus),    64'(0));
      chk("rst_diff",     64'(bus.difficulty), 64'(4));
      chk("rst_song",     64'(bus.song),       64'(0));
      chk("rst_mode_idx", 64'(bus.mode_idx),   64'(0));
      chk("rst_we",       64'(bus.remap_we),   64'(0));
      rst_n = 1'b1;
      cyc(4);
      chk("menu_out_bus", 64'(bus.out_bus), 64'(MENU));

      // Mode 0 (no song): acts on the third edge after the press is sampled
      bus.note_key = 7'b0000001;
      bus.submit   = 1'b1;
      cyc(1);
      chk("lat_edge1", 64'(bus.state), 64'(0));
      cyc(1);
      chk("lat_edge2", 64'(bus.state), 64'(0));
      cyc(1);
      chk("lat_edge3_state", 64'(bus.state),   64'(2));
      chk("lat_edge3_en",    64'(bus.mode_en), 64'(4'b0001));
      chk("run_out_prev",    64'(bus.out_bus), 64'(MENU));
      cyc(1);
      chk("run0_out_bus", 64'(bus.out_bus), 64'(SL0));
      cyc(3);
      chk("run0_held_submit", 64'(bus.state), 64'(2));
      bus.submit = 1'b0;
      cyc(2);
      press(4'b0010);
      chk("cancel_state", 64'(bus.state),   64'(0));
      chk("cancel_en",    64'(bus.mode_en), 64'(0));
      chk("cancel_out",   64'(bus.out_bus), 64'(MENU));

      // Mode 3: song select with difficulty adjust
      bus.note_key = 7'b0001000;
      press(4'b0001);
      chk("sel3_state", 64'(bus.state),      64'(1));
      chk("sel3_idx",   64'(bus.mode_idx),   64'(3));
      chk("sel3_diff",  64'(bus.difficulty), 64'(4));
      chk("sel3_en",    64'(bus.mode_en),    64'(0));
      press(4'b0100);
      chk("up1", 64'(bus.difficulty), 64'(5));
      press(4'b0100);
      chk("up2", 64'(bus.difficulty), 64'(6));
      press(4'b0100);
      chk("up3_sat", 64'(bus.difficulty), 64'(6));
      press(4'b1000);
      chk("down1", 64'(bus.difficulty), 64'(5));
      press(4'b1100);
      chk("up_down_same", 64'(bus.difficulty), 64'(5));
      bus.note_key = 7'b0000100;
      press(4'b0001);
      chk("bad_song_stay", 64'(bus.state), 64'(1));
      bus.note_key   = 7'b0000010;
      bus.length_key = 7'b0000100;
      press(4'b0001);
      chk("song_state", 64'(bus.state),    64'(2));
      chk("song_num",   64'(bus.song),     64'(2));
      chk("song_sub",   64'(bus.sub_mode), 64'(2));
      chk("song_en",    64'(bus.mode_en),  64'(4'b1000));
      chk("run3_out",   64'(bus.out_bus),  64'(SL3));

      // Cancel and submit together in RUN
      press(4'b0011);
      chk("cs_state", 64'(bus.state),   64'(0));
      chk("cs_song",  64'(bus.song),    64'(0));
      chk("cs_en",    64'(bus.mode_en), 64'(0));
      chk("cs_out",   64'(bus.out_bus), 64'(MENU));

      // Mode 1: no difficulty adjust, out-of-range length key
      bus.note_key = 7'b0000010;
      press(4'b0001);
      chk("sel1_state", 64'(bus.state), 64'(1));
      press(4'b0100);
      chk("sel1_no_adj", 64'(bus.difficulty), 64'(4));
      bus.note_key   = 7'b0000001;
      bus.length_key = 7'b0010000;
      press(4'b0001);
      chk("run1_song", 64'(bus.song),     64'(1));
      chk("run1_sub",  64'(bus.sub_mode), 64'(0));
      chk("run1_en",   64'(bus.mode_en),  64'(4'b0010));
      chk("run1_out",  64'(bus.out_bus),  64'(SL1));
      press(4'b0010);

      // Full remap sweep
      bus.note_key = 7'b0010000;
      press(4'b0001);
      chk("remap_state", 64'(bus.state),      64'(3));
      chk("remap_addr0", 64'(bus.remap_addr), 64'(0));
      for (int k = 0; k < KEYS; k++) begin
         bus.note_key = 7'(1 << k);
         press(4'b0001);
         chk($sformatf("remap_st%0d", k), 64'(bus.state), (k < KEYS - 1) ? 64'(3) : 64'(0));
      end
      chk("we_cnt7",  64'(we_cnt),  64'(7));
      chk("cue_cnt7", 64'(cue_cnt), 64'(7));
      for (int k = 0; k < KEYS; k++) begin
         if (k < we_addr.size()) begin
            chk($sformatf("we_addr%0d", k), 64'(we_addr[k]), 64'(k));
            chk($sformatf("we_data%0d", k), 64'(we_data[k]), 64'(1 << k));
         end
      end

      // Busy cue and invalid keys give no write
      bus.note_key = 7'b0010000;
      press(4'b0001);
      bus.cue_busy = 1'b1;
      bus.note_key = 7'b0000001;
      press(4'b0001);
      chk("busy_no_we",  64'(we_cnt),    64'(7));
      chk("busy_no_cue", 64'(cue_cnt),   64'(7));
      chk("busy_state",  64'(bus.state), 64'(3));
      bus.cue_busy = 1'b0;
      bus.note_key = 7'b0000011;
      press(4'b0001);
      chk("multi_no_we", 64'(we_cnt), 64'(7));
      for (int k = 0; k < 3; k++) begin
         bus.note_key = 7'(1 << k);
         press(4'b0001);
      end
      chk("we_cnt10",  64'(we_cnt),         64'(10));
      chk("addr_last", 64'(bus.remap_addr), 64'(2));
      bus.remap_clr = 1'b1;
      cyc(1);
      chk("clr_rst_pulse", 64'(bus.remap_rst),  64'(1));
      chk("clr_state",     64'(bus.state),      64'(0));
      chk("clr_addr",      64'(bus.remap_addr), 64'(0));
      bus.remap_clr = 1'b0;
      cyc(1);
      chk("clr_rst_low", 64'(bus.remap_rst), 64'(0));
      chk("rst_cnt1",    64'(rst_cnt),       64'(1));
      bus.note_key = 7'b0010000;
      press(4'b0001);
      bus.note_key = 7'b1000000;
      press(4'b0001);
      chk("post_clr_we", 64'(we_cnt), 64'(11));
      if (we_addr.size() > 10) begin
         chk("post_clr_addr", 64'(we_addr[10]), 64'(0));
         chk("post_clr_data", 64'(we_data[10]), 64'(7'b1000000));
      end
      press(4'b0010);
      chk("remap_cancel", 64'(bus.state), 64'(0));

      // Invalid keys in MENU
      bus.note_key = 7'b0000011;
      press(4'b0001);
      chk("menu_multi", 64'(bus.state), 64'(0));
      bus.note_key = 7'b0000000;
      press(4'b0001);
      chk("menu_zero", 64'(bus.state), 64'(0));
      bus.note_key = 7'b0100000;
      press(4'b0001);
      chk("menu_key5", 64'(bus.state), 64'(0));

      // Reset mid-RUN with submit held through release
      bus.note_key = 7'b0000001;
      press(4'b0001);
      chk("pre_rst_run", 64'(bus.state), 64'(2));
      bus.submit = 1'b1;
      rst_n      = 1'b0;
      cyc(2);
      chk("mid_rst_state", 64'(bus.state),   64'(0));
      chk("mid_rst_en",    64'(bus.mode_en), 64'(0));
      chk("mid_rst_out",   64'(bus.out_bus), 64'(0));
      rst_n = 1'b1;
      cyc(6);
      chk("held_no_pulse", 64'(bus.state), 64'(0));
      bus.submit = 1'b0;
      cyc(2);
      press(4'b0001);
      chk("repress_run", 64'(bus.state), 64'(2));
      chk("no_spurious_we", 64'(we_cnt), 64'(11));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mode_dispatcher.md
MODE_DISPATCHER -- requirements
Module: mode_dispatcher

Interface
REQ-001 Parameters (name, default, meaning): KEYS, 7, note/length key count; NUM_MODES, 4, play modes; NUM_SONGS, 2, selectable songs; OUT_W, 24, per-mode output bundle width; NOSONG_MASK, 4'b0001, mode bit=1 means no song select; DIFF_MASK, 4'b1000, mode bit=1 means difficulty adjust in select; DIFF_DEF, 4, difficulty on entry; DIFF_MAX, KEYS-1, difficulty ceiling.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 submit, cancel, oct_up, oct_down  in  1 each  raw button levels, asynchronous to clk.
REQ-005 note_key, length_key  in  KEYS each  switch levels, one-hot when valid.
REQ-006 remap_clr  in  1  level; clears key-remap table while in REMAP.
REQ-007 cue_busy  in  1  chime player busy.
REQ-008 mode_bus  in  NUM_MODES*OUT_W  mode i bundle at slice [i*OUT_W +: OUT_W].
REQ-009 menu_bus  in  OUT_W  menu/display bundle.
REQ-010 out_bus  out  OUT_W  registered selected bundle.
REQ-011 mode_en  out  NUM_MODES  one-hot run enable, or zero.
REQ-012 state  out  3  0=MENU, 1=SELECT, 2=RUN, 3=REMAP.
REQ-013 mode_idx  out  clog2(NUM_MODES)  current mode index.
REQ-014 song  out  clog2(NUM_SONGS+1)  0=none, j+1=song j.
REQ-015 sub_mode  out  2  play sub-mode.
REQ-016 difficulty  out  4  difficulty level.
REQ-017 remap_we, remap_rst, cue_start  out  1 each  single-cycle pulses.
REQ-018 remap_addr  out  clog2(KEYS)  remap write address.
REQ-019 remap_data  out  KEYS  remap write data.

Function
REQ-020 Buttons: each raw input passes 2-FF sync plus 1 history FF; pulse = sync & ~history; one clk high per press; FSM acts on 3rd clk edge after raw first sampled high.
REQ-021 Valid key = exactly one bit set; zero or multi-hot keys treated as no selection.
REQ-022 MENU + submit, note_key bit i < NUM_MODES: mode_idx=i; song=0; difficulty=DIFF_DEF; next RUN if NOSONG_MASK[i], else SELECT.
REQ-023 MENU + submit, note_key bit NUM_MODES: REMAP, remap_addr=0; any other key: stay MENU.
REQ-024 SELECT + submit, note_key bit j < NUM_SONGS: song=j+1; sub_mode = index of one-hot length_key if 0..3, else 0; next RUN; otherwise stay SELECT.
REQ-025 SELECT with DIFF_MASK[mode_idx]: up pulse +1 saturating at DIFF_MAX; down -1 saturating at 0; both in same cycle: no change.
REQ-026 RUN: mode_en = 1<<mode_idx; out_bus <= mode_bus slice mode_idx, one cycle latency; submit ignored.
REQ-027 MENU, SELECT, REMAP: mode_en=0; out_bus <= menu_bus, one cycle latency.
REQ-028 cancel pulse in any state except MENU: next state MENU, song=0, mode_en=0 next cycle; cancel beats submit in same cycle; cancel in MENU ignored.
REQ-029 REMAP + submit, valid note_key, cue_busy=0: remap_we=1 for one cycle, remap_data=note_key, remap_addr=current index; cue_start=1 same cycle; index +1.
REQ-030 Write at index KEYS-1 returns to MENU next cycle; index never wraps past KEYS-1.
REQ-031 REMAP submit with cue_busy=1 or invalid key: no write, no cue, index unchanged.
REQ-032 REMAP + remap_clr high: remap_rst=1 one cycle; index=0; next MENU; beats submit in same cycle.
REQ-033 mode_en changes only on state transitions; never more than one bit set.

Reset
REQ-034 rst_n low, asynchronous: state=MENU, mode_idx=0, song=0, sub_mode=0, difficulty=DIFF_DEF, remap index 0, out_bus=0, mode_en=0; all pulses 0; sync FFs 0.
REQ-035 Reset mid-RUN or mid-REMAP discards progress; no remap_we or cue_start emitted during or after reset; button held across release produces no pulse until released and pressed again.

Verification
REQ-036 Reset, note_key=0000001, submit: RUN, mode_en=0001, out_bus = mode_bus[23:0] one cycle later.
REQ-037 note_key=0001000, submit: SELECT, difficulty=4. Three up presses -> 6 (saturated). note_key=0000010, length_key=0000100, submit -> song=2, sub_mode=2, mode_en=1000.
REQ-038 In RUN, cancel and submit pressed simultaneously: MENU, song=0, mode_en=0000, out_bus=menu_bus.
REQ-039 REMAP: seven submits with keys 1<<k, cue_busy=0 -> remap_we at addr 0..6, data matching, 7 cue_start pulses, then MENU; submit with cue_busy=1 -> no write.
REQ-040 REMAP after 3 writes, remap_clr=1 -> remap_rst pulse, index 0, MENU; multi-hot key submit in MENU -> stays MENU.
